phase_accu_pipe: RTL
====================

Name: phase_accu_pipe

Overview:
- Parametrised, fully pipelined DDS phase calculator; next generation of the DAC controller's fixed 48-bit phase MAC.
- Computes phase = acc + (((time − offset) × freq) >> FRAC_SHIFT) + (phase_ofs aligned to MSB), modulo 2^OUT_W.
- Adds a valid-qualified pipeline and an internal phase-continuity register, so a channel can rebase its accumulated phase on a frequency change without software round-trips.
- Sits between the timestamp/parameter FIFO and the DDS output stage.

Parameters:
TIME_W, 48, width of timestamp and time offset
FREQ_W, 48, width of frequency tuning word
PHASE_W, 14, width of static phase offset
OUT_W, 48, width of accumulated and output phase
FRAC_SHIFT, 4, LSBs dropped from the product before alignment to OUT_W

Ports:
clk  in  1  system clock
resetn  in  1  reset; asynchronous assert, active-low
in_valid  in  1  sample strobe, one sample per cycle max
in_time  in  TIME_W  timestamp
in_offset  in  TIME_W  time offset
in_freq  in  FREQ_W  frequency word
in_phase  in  PHASE_W  static phase offset
in_acc  in  OUT_W  external accumulated phase
in_acc_sel  in  1  0: use in_acc; 1: use internal acc_reg
in_latch  in  1  store this sample's result into acc_reg on exit
acc_clr  in  1  synchronous clear of acc_reg
out_valid  out  1  result strobe
out_phase  out  OUT_W  result phase
acc_reg_o  out  OUT_W  current internal accumulated phase

Behaviour:
- Reset: resetn low asynchronously forces out_valid=0, out_phase=0, acc_reg=0, and all pipeline valid bits=0. Data registers may be left uncleared, but no stale valid may emerge after reset deassertion.
- Latency: fixed 5 cycles for every parameter set. A sample accepted at cycle N with in_valid=1 yields out_valid=1 at N+5.
  - No backpressure; throughput is 1 sample per cycle.
  - Bubbles propagate as out_valid=0.
  - out_phase holds its last value while out_valid=0.
- Arithmetic:
  - diff = (in_time − in_offset) mod 2^TIME_W, unsigned; wrap is legal.
  - prod = diff × in_freq, unsigned, full TIME_W+FREQ_W bits.
  - term = prod[FRAC_SHIFT+OUT_W−1 : FRAC_SHIFT]; bits above are discarded.
  - pofs = in_phase << (OUT_W − PHASE_W).
  - out_phase = (accv + term + pofs) mod 2^OUT_W.
- Multiplier: may be split into 16/17-bit partial products across stages 1–3. Only the modular result above is normative.
- Accumulator operand accv:
  - Sampled at the input cycle: in_acc if in_acc_sel=0, else acc_reg as it stands in that cycle.
  - It is carried with the sample, so later acc_reg changes do not affect samples already in flight.
- Latch:
  - A sample with in_latch=1 writes its out_phase into acc_reg in the same cycle it appears on out_valid; the new value is visible from the next cycle.
  - A sample entering in that exit cycle with in_acc_sel=1 still sees the old acc_reg.
- acc_clr:
  - acc_reg becomes 0 the next cycle.
  - If a latch commit coincides with acc_clr, acc_clr wins.
  - acc_clr does not affect samples in flight.
- in_latch, in_acc_sel, in_phase and in_acc are ignored when in_valid=0.
- acc_reg_o mirrors acc_reg combinationally from the register.
- Reset mid-operation: all in-flight samples are dropped; out_valid=0 until new samples traverse 5 stages after resetn rises.
- No X on out_phase while out_valid=1 under defined inputs.

Test Plan:
- Basic: time=0x64, offset=0x14, freq=0x10, phase=0, acc=0, sel=0 → diff=0x50, prod=0x500, out_phase=0x50 at N+5 with out_valid=1.
- Wrap and offset:
  - time=0x0, offset=0x1, freq=0x10, acc=0 → diff=2^48−1; out_phase=(0xF_FFFF_FFFF_FFF0>>4) mod 2^48=0xFFFF_FFFF_FFFF.
  - phase=0x2000, time=offset, acc=5 → out_phase=0x8000_0000_0005.
- Back-to-back: 8 consecutive valid samples with distinct time values, then a 2-cycle bubble → 8 consecutive correct outputs at N+5..N+12, then out_valid=0 for 2 cycles.
- Latch and continuity:
  - Sample A: in_latch=1, result 0x1234 → acc_reg_o=0x1234 from cycle N+6.
  - Sample B with sel=1 entering at N+6, time=offset, phase=0 → out 0x1234.
  - Sample C with sel=1 entering at N+5 → uses old acc_reg=0.
- Clear priority: latch commit and acc_clr in the same cycle → acc_reg_o=0 next cycle.
- Reset: assert resetn low asynchronously mid-stream with 3 samples in flight → out_valid, out_phase and acc_reg_o go to 0 immediately; after release with no new input, out_valid stays 0.

Source files
------------

// File: rtl/phase_accu_pipe.sv
// Purpose : DDS phase calculator, phase = acc + ((time-offset)*freq >> FRAC_SHIFT) + (phase_ofs << (OUT_W-PHASE_W)) mod 2^OUT_W.
// Latency : fixed 5 cycles from in_valid to out_valid, one sample per cycle.
// Backpressure: none; bubbles travel down the pipe as out_valid=0.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   in_valid                 sample strobe qualifying every in_* field
//   in_time, in_offset       timestamp and time offset (TIME_W)
//   in_freq                  frequency tuning word (FREQ_W)
//   in_phase                 static phase offset, aligned to the output MSB (PHASE_W)
//   in_acc, in_acc_sel       external accumulator, or internal acc_reg when in_acc_sel=1
//   in_latch                 store this sample's result into acc_reg when it exits
//   acc_clr                  synchronous clear of acc_reg, wins over a latch commit
//   out_valid, out_phase     result strobe and phase (phase holds while out_valid=0)
//   acc_reg_o                current internal accumulated phase
module phase_accu_pipe #(
   parameter int TIME_W     = 48,
   parameter int FREQ_W     = 48,
   parameter int PHASE_W    = 14,
   parameter int OUT_W      = 48,
   parameter int FRAC_SHIFT = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                in_valid,
   input  logic [TIME_W-1:0]   in_time,
   input  logic [TIME_W-1:0]   in_offset,
   input  logic [FREQ_W-1:0]   in_freq,
   input  logic [PHASE_W-1:0]  in_phase,
   input  logic [OUT_W-1:0]    in_acc,
   input  logic                in_acc_sel,
   input  logic                in_latch,
   input  logic                acc_clr,
   output logic                out_valid,
   output logic [OUT_W-1:0]    out_phase,
   output logic [OUT_W-1:0]    acc_reg_o
);

   // The difference is cut into 16-bit chunks; each chunk times the full
   // frequency word is one partial product.
   localparam int NCH = (TIME_W + 15) / 16;
   localparam int DPW = NCH * 16;
   localparam int PPW = 16 + FREQ_W;
   // Only product bits up to FRAC_SHIFT+OUT_W-1 can reach the output.
   localparam int PSW = FRAC_SHIFT + OUT_W;

   logic [OUT_W-1:0]   acc_reg;
   logic               s1_vld, s2_vld, s3_vld, s4_vld;
   logic               out_latch;

   logic [TIME_W-1:0]  s1_diff;
   logic [FREQ_W-1:0]  s1_freq;
   logic [OUT_W-1:0]   s1_base, s2_base, s3_base;
   logic               s1_lat, s2_lat, s3_lat, s4_lat;
   logic [PPW-1:0]     s2_pp [NCH];
   logic [OUT_W-1:0]   s3_term;
   logic [OUT_W-1:0]   s4_sum;

   logic [OUT_W-1:0]   accv;
   logic [OUT_W-1:0]   pofs;
   logic [DPW-1:0]     diff_pad;
   logic [PSW-1:0]     prod_sum;
   logic [OUT_W-1:0]   term;

   // Accumulator operand is resolved at entry and carried with the sample,
   // so later acc_reg updates never reach samples already in flight.
   assign accv     = in_acc_sel ? acc_reg : in_acc;
   assign pofs     = OUT_W'(in_phase) << (OUT_W - PHASE_W);
   assign diff_pad = DPW'(s1_diff);

   // Recombine partial products; bits at or above PSW fall off, which is
   // exactly the modulo behaviour wanted at the output.
   always_comb begin
      prod_sum = '0;
      for (int i = 0; i < NCH; i++) begin
         prod_sum = prod_sum + (PSW'(s2_pp[i]) << (16 * i));
      end
      term = OUT_W'(prod_sum >> FRAC_SHIFT);
   end

   // Valid chain, output and accumulator state: the only reset flops.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_vld    <= 1'b0;
         s2_vld    <= 1'b0;
         s3_vld    <= 1'b0;
         s4_vld    <= 1'b0;
         out_valid <= 1'b0;
         out_latch <= 1'b0;
         out_phase <= '0;
         acc_reg   <= '0;
      end else begin
         s1_vld    <= in_valid;
         s2_vld    <= s1_vld;
         s3_vld    <= s2_vld;
         s4_vld    <= s3_vld;
         out_valid <= s4_vld;
         out_latch <= s4_vld & s4_lat;
         if (s4_vld) begin
            out_phase <= s4_sum;
         end
         // Commit happens in the exit cycle, so the new value is seen from
         // the following cycle; a clear in the same cycle takes priority.
         if (acc_clr) begin
            acc_reg <= '0;
         end else if (out_valid && out_latch) begin
            acc_reg <= out_phase;
         end
      end
   end

   // Data path: no reset, each stage loads only under its valid.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         s1_diff <= in_time - in_offset;
         s1_freq <= in_freq;
         s1_base <= accv + pofs;
         s1_lat  <= in_latch;
      end
      if (s1_vld) begin
         for (int i = 0; i < NCH; i++) begin
            s2_pp[i] <= PPW'(diff_pad[16*i +: 16]) * PPW'(s1_freq);
         end
         s2_base <= s1_base;
         s2_lat  <= s1_lat;
      end
      if (s2_vld) begin
         s3_term <= term;
         s3_base <= s2_base;
         s3_lat  <= s2_lat;
      end
      if (s3_vld) begin
         s4_sum <= s3_base + s3_term;
         s4_lat <= s3_lat;
      end
   end

   assign acc_reg_o = acc_reg;

endmodule
